nibble_deserializer: RTL and testbench
======================================

Name: nibble_deserializer

Overview:
- Upstream feeder for the 4-bit prime / divisible-by-3 classifier.
- Assembles a framed serial bit stream into 4-bit nibbles and buffers them in a small FIFO.
- Presents each nibble with a valid/ready handshake. Nibble bits map to the classifier inputs as a = bit3, b = bit2, c = bit1, d = bit0.
- Tracks framing errors, FIFO overruns and a running count of delivered nibbles.

Parameters:
- MSB_FIRST, 1: 1 = first serial bit of a nibble lands in bit3; 0 = first bit lands in bit0.
- DEPTH, 2: output FIFO depth in nibbles, power of two, minimum 2.
- CNT_W, 8: width of nibble_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled on this edge.
- frame_start  input  1  qualified by ser_valid; marks the current bit as bit index 0 of a nibble.
- clr_flags  input  1  synchronous clear of frame_err and overrun.
- out_nibble  output  4  FIFO head nibble {a,b,c,d}.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head when out_valid && out_ready.
- frame_err  output  1  sticky: a partial nibble was aborted.
- overrun  output  1  sticky: a completed nibble was dropped because the FIFO was full.
- nibble_count  output  CNT_W  nibbles pushed into the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high): clk and rst as named above. While rst is high, all state clears immediately:
  - FSM = IDLE, bit counter = 0, shift register = 0, FIFO empty.
  - out_valid = 0, out_nibble = 0, frame_err = 0, overrun = 0, nibble_count = 0.
  - A reset mid-nibble or with a non-empty FIFO discards everything; no partial output is ever produced.
- FSM states:
  - IDLE: bits ignored until ser_valid && frame_start. That bit is captured as index 0, bit counter = 1, go to SHIFT.
  - SHIFT: each ser_valid captures one bit and increments the counter.
    - When the 4th bit (index 3) is captured, the complete nibble is pushed on the same edge and the counter returns to 0.
    - The FSM stays in SHIFT, so back-to-back nibbles need no new frame_start.
    - ser_valid low: hold all state, no timeout.
- frame_start in SHIFT with counter 1..3: the partial nibble is discarded and frame_err is set. The current bit becomes index 0 of a new nibble (counter = 1).
- frame_start in SHIFT with counter 0: a normal nibble boundary, no error.
- Bit placement:
  - MSB_FIRST = 1: shift left, new bit enters bit0; after 4 bits the first bit sits in bit3.
  - MSB_FIRST = 0: first bit is bit0, fourth bit is bit3.
- Latency: the edge that captures the 4th bit writes the FIFO. If the FIFO was empty, out_valid and out_nibble are valid in the following cycle, i.e. 1 cycle after the last bit is sampled.
- FIFO rules:
  - Pop on out_valid && out_ready.
  - out_nibble shows the head and is stable while out_valid && !out_ready.
  - Push while full with no pop on the same edge: the nibble is dropped, overrun is set, nibble_count is unchanged.
  - Push and pop on the same edge while full: both occur, no overrun.
  - Push and pop on the same edge while holding one entry: occupancy stays 1 and the new nibble becomes the head.
  - Pop while empty is ignored.
- nibble_count increments by 1 on every successful push and wraps from 2^CNT_W-1 to 0.
- Sticky flags (frame_err, overrun):
  - Cleared by clr_flags on the next edge.
  - If a set condition and clr_flags occur on the same edge, set wins.

Decomposition:
- Package nibble_pkg holds:
  - the state enum {IDLE, SHIFT};
  - NIBBLE_W = 4;
  - the bit-counter width (2);
  - a helper function placing a bit according to MSB_FIRST.
- One sub-module, nibble_fifo (DEPTH x 4, push/pop/full/empty, asynchronous reset), instantiated once. The top level holds the FSM, shift register, flags and counter.

Test Plan:
- Reset, then ser_in 0,1,0,1 with frame_start on the first bit, MSB_FIRST = 1, out_ready = 1 -> out_nibble = 4'b0101 (5) with out_valid high exactly one cycle after the 4th bit; nibble_count = 1.
- Continuous stream 0011 1100 1111, frame_start on the first bit only -> nibbles 3, 12, 15 in order; frame_err = 0; nibble_count = 3.
- Bits 1,1 then frame_start with bits 0,1,1,1 -> only 4'b0111 is delivered; frame_err = 1. clr_flags asserted -> frame_err = 0 on the next cycle.
- out_ready = 0, three nibbles 2, 9, 6 sent -> FIFO holds 2, 9; overrun = 1; nibble_count = 2. Raising out_ready pops 2 then 9, then out_valid = 0.
- With the FIFO full, the 4th bit of a new nibble arrives on the same edge as a pop -> no overrun; the new nibble is delivered after the older entry.
- Assert rst asynchronously mid-nibble (after 2 bits) and while the FIFO holds one entry -> all outputs 0 immediately. The first nibble after reset needs a new frame_start, and bits sent without it are ignored.

Source files
------------

// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared types, widths and bit placement for the nibble deserializer
package nibble_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int NIBBLE_W = 4;
  localparam int CNT_BITS = 2;

  // MSB-first shifts the nibble left; LSB-first writes the bit at its index
  function automatic logic [NIBBLE_W-1:0] place_bit(
    input logic [NIBBLE_W-1:0] cur,
    input logic                b,
    input logic [CNT_BITS-1:0] idx,
    input logic                msb_first
  );
    logic [NIBBLE_W-1:0] r;
    if (msb_first) begin
      r = {cur[NIBBLE_W-2:0], b};
    end else begin
      r = cur;
      r[idx] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// rtl/nibble_fifo.sv - DEPTH-entry nibble FIFO with same-edge push/pop when full
module nibble_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign empty   = (occ == '0);
  assign full    = (occ == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop on the same edge frees the slot a full FIFO needs for the push
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/nibble_deserializer.sv
// rtl/nibble_deserializer.sv - framed serial-to-nibble assembler feeding a small output FIFO
module nibble_deserializer
  import nibble_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ser_in,
  input  logic                ser_valid,
  input  logic                frame_start,
  input  logic                clr_flags,
  output logic [NIBBLE_W-1:0] out_nibble,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err,
  output logic                overrun,
  output logic [CNT_W-1:0]    nibble_count
);

  state_t              state;
  logic [CNT_BITS-1:0] bit_cnt;
  logic [NIBBLE_W-1:0] shreg;

  logic                capture;
  logic                restart;
  logic                abort;
  logic                push;
  logic                push_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_BITS-1:0] idx;
  logic [NIBBLE_W-1:0] next_shreg;

  assign restart    = ser_valid && frame_start;
  assign capture    = ser_valid && (frame_start || state == SHIFT);
  assign abort      = restart && (state == SHIFT) && (bit_cnt != '0);
  assign idx        = restart ? '0 : bit_cnt;
  // index 0 always starts from a clean register so stale bits never leak
  assign next_shreg = place_bit((idx == '0) ? '0 : shreg, ser_in, idx, MSB_FIRST);
  assign push       = capture && !frame_start && (bit_cnt == 2'd3);
  assign push_ok    = !fifo_full || out_ready;
  assign out_valid  = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      nibble_count <= '0;
    end else begin
      if (capture) begin
        state   <= SHIFT;
        shreg   <= next_shreg;
        bit_cnt <= idx + 2'd1;
      end
      frame_err <= abort | (frame_err & ~clr_flags);
      overrun   <= (push & ~push_ok) | (overrun & ~clr_flags);
      if (push && push_ok) nibble_count <= nibble_count + 1'b1;
    end
  end

  nibble_fifo #(
    .DEPTH (DEPTH),
    .W     (NIBBLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (next_shreg),
    .pop       (out_ready),
    .head      (out_nibble),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_nibble_deserializer.sv
// tb/tb_nibble_deserializer.sv - scoreboard bench with a queue-based reference model
module tb_nibble_deserializer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic             clr_flags;
  logic [3:0]       out_nibble;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             overrun;
  logic [CNT_W-1:0] nibble_count;

  always #5 clk = ~clk;

  nibble_deserializer #(
    .MSB_FIRST (1'b1),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_in       (ser_in),
    .ser_valid    (ser_valid),
    .frame_start  (frame_start),
    .clr_flags    (clr_flags),
    .out_nibble   (out_nibble),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .nibble_count (nibble_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: expected nibbles in delivery order plus frame bookkeeping
  logic [3:0] sb[$];
  int         occ;
  bit         in_frame;
  int         nb;
  int         bits[4];
  bit         e_ferr;
  bit         e_ovr;
  int         e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0d expected no output", out_nibble);
      end else begin
        e = sb.pop_front();
        chk("pop_nibble", {28'd0, out_nibble}, {28'd0, e});
      end
    end
  end

  task automatic model_clear();
    sb.delete();
    occ      = 0;
    in_frame = 0;
    nb       = 0;
    e_ferr   = 0;
    e_ovr    = 0;
    e_cnt    = 0;
  endtask

  task automatic step(input logic sv, input logic fs, input logic b, input logic rdy, input logic clr);
    bit pop;
    bit push;
    bit ferr_set;
    bit ovr_set;
    int nib;
    ser_valid   = sv;
    frame_start = fs;
    ser_in      = b;
    out_ready   = rdy;
    clr_flags   = clr;
    pop      = (occ > 0) && rdy;
    push     = 0;
    ferr_set = 0;
    ovr_set  = 0;
    nib      = 0;
    if (sv) begin
      if (fs) begin
        if (in_frame && nb != 0) ferr_set = 1;
        in_frame = 1;
        bits[0]  = int'(b);
        nb       = 1;
      end else if (in_frame) begin
        bits[nb] = int'(b);
        nb++;
        if (nb == 4) begin
          push = 1;
          nb   = 0;
          for (int i = 0; i < 4; i++) nib += bits[i] << (3 - i);
        end
      end
    end
    if (push) begin
      if (occ < DEPTH || pop) begin
        sb.push_back(4'(nib));
        e_cnt = (e_cnt + 1) % (1 << CNT_W);
        occ++;
      end else begin
        ovr_set = 1;
      end
    end
    if (pop) occ--;
    e_ferr = ferr_set || (e_ferr && !clr);
    e_ovr  = ovr_set || (e_ovr && !clr);
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, (occ > 0) ? 32'd1 : 32'd0);
    chk("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
    chk("overrun", {31'd0, overrun}, {31'd0, e_ovr});
    chk("nibble_count", {24'd0, nibble_count}, 32'(e_cnt));
  endtask

  task automatic send_nib(input logic [3:0] v, input logic fs_first, input logic rdy);
    logic [3:0] vv;
    vv = v;
    for (int i = 0; i < 4; i++) step(1'b1, fs_first && (i == 0), vv[3-i], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy, input logic clr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, clr);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_nibble"}, {28'd0, out_nibble}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_count"}, {24'd0, nibble_count}, 32'd0);
  endtask

  // asserts rst between edges and checks outputs clear without waiting for a clock
  task automatic apply_reset(input string tag);
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero(tag);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    ser_in      = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    clr_flags   = 1'b0;
    out_ready   = 1'b0;
    model_clear();
    #3 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // single nibble, one cycle latency after the 4th bit
    send_nib(4'd5, 1'b1, 1'b1);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_nibble", {28'd0, out_nibble}, 32'd5);
    chk("t1_count", {24'd0, nibble_count}, 32'd1);
    idle(2, 1'b1, 1'b0);

    // back-to-back nibbles without new frame_start
    apply_reset("rst2");
    send_nib(4'd3, 1'b1, 1'b1);
    send_nib(4'd12, 1'b0, 1'b1);
    send_nib(4'd15, 1'b0, 1'b1);
    chk("t2_ferr", {31'd0, frame_err}, 32'd0);
    chk("t2_count", {24'd0, nibble_count}, 32'd3);
    idle(2, 1'b1, 1'b0);

    // aborted partial nibble then clear
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_nib(4'd7, 1'b1, 1'b1);
    chk("t3_ferr", {31'd0, frame_err}, 32'd1);
    chk("t3_count", {24'd0, nibble_count}, 32'd4);
    idle(1, 1'b1, 1'b1);
    chk("t3_ferr_clr", {31'd0, frame_err}, 32'd0);
    idle(1, 1'b1, 1'b0);

    // overrun with consumer stalled
    apply_reset("rst4");
    send_nib(4'd2, 1'b1, 1'b0);
    send_nib(4'd9, 1'b0, 1'b0);
    send_nib(4'd6, 1'b0, 1'b0);
    chk("t4_ovr", {31'd0, overrun}, 32'd1);
    chk("t4_count", {24'd0, nibble_count}, 32'd2);
    chk("t4_head", {28'd0, out_nibble}, 32'd2);
    idle(2, 1'b1, 1'b1);
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // full FIFO: push and pop on the same edge
    send_nib(4'd1, 1'b0, 1'b0);
    send_nib(4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, (i == 0) ? 1'b1 : (i == 2), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_ovr", {31'd0, overrun}, 32'd0);
    chk("t5_head", {28'd0, out_nibble}, 32'd4);
    idle(3, 1'b1, 1'b0);

    // reset mid-nibble with one entry buffered
    send_nib(4'd6, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_reset("rst6");
    send_nib(4'd13, 1'b0, 1'b1);
    chk("t6_ignored", {31'd0, out_valid}, 32'd0);
    chk("t6_count", {24'd0, nibble_count}, 32'd0);
    send_nib(4'd9, 1'b1, 1'b1);
    chk("t6_nibble", {28'd0, out_nibble}, 32'd9);
    idle(2, 1'b1, 1'b0);

    // randomized traffic, long enough to wrap nibble_count
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 8) == 0, 1'($urandom), ($urandom % 3) != 0,
           ($urandom % 16) == 0);
    end
    idle(4, 1'b1, 1'b0);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
